// File: rtl/sr_mul_seq.sv
// Multi-cycle MUL sequencer for the schoolRISCV core: shift-add multiply retiring
// STEP multiplier bits per cycle, stalling the PC until a one-cycle vld pulse.
module sr_mul_seq #(
  parameter int WIDTH = 32,
  parameter int STEP  = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             mulReq,
  input  logic [WIDTH-1:0] srcA,
  input  logic [WIDTH-1:0] srcB,
  output logic             stall,
  output logic             vld,
  output logic [WIDTH-1:0] result,
  output logic             busy
);

  localparam int K  = WIDTH / STEP;
  localparam int CW = $clog2(K + 1);

  generate
    if ((WIDTH % STEP) != 0) begin : g_bad_step
      $error("sr_mul_seq: STEP must divide WIDTH");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] acc_q;
  logic [WIDTH-1:0] mcand_q;
  logic [WIDTH-1:0] mplier_q;
  logic [WIDTH-1:0] result_q;
  logic             vld_q;
  logic             busy_q;

  logic [WIDTH-1:0] partial;
  logic [WIDTH-1:0] acc_d;

  // Partial product of the multiplicand with the low STEP multiplier bits, truncated.
  always_comb begin
    partial = '0;
    acc_d   = '0;
    partial = mcand_q * {{(WIDTH-STEP){1'b0}}, mplier_q[STEP-1:0]};
    acc_d   = acc_q + partial;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      result_q <= '0;
      vld_q    <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (mulReq) begin
            mcand_q  <= srcA;
            mplier_q <= srcB;
            acc_q    <= '0;
            cnt_q    <= CW'(K);
            busy_q   <= 1'b1;
            state_q  <= BUSY;
          end
        end
        BUSY: begin
          acc_q    <= acc_d;
          mcand_q  <= mcand_q << STEP;
          mplier_q <= mplier_q >> STEP;
          cnt_q    <= cnt_q - CW'(1);
          if (cnt_q == CW'(1)) begin
            result_q <= acc_d;
            vld_q    <= 1'b1;
            state_q  <= DONE;
          end
        end
        DONE: begin
          // mulReq is still high for the retiring instruction; never restart from here.
          vld_q   <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          vld_q   <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign stall  = ~rst & (((state_q == IDLE) & mulReq) | (state_q == BUSY));
  assign vld    = vld_q;
  assign result = result_q;
  assign busy   = busy_q;

endmodule

// File: tb/tb_sr_mul_seq.sv
// Self-checking bench for sr_mul_seq: directed corner products plus randomized
// transactions compared cycle by cycle against a transaction-level timing/product model.
module tb_sr_mul_seq;

  localparam int W = 32;
  localparam int S = 4;
  localparam int K = W / S;

  logic         clk = 1'b0;
  logic         rst;
  logic         mul_req;
  logic [W-1:0] src_a;
  logic [W-1:0] src_b;
  logic         stall;
  logic         vld;
  logic [W-1:0] result;
  logic         busy;

  int           n_checks = 0;
  int           n_pass   = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] last_result;

  sr_mul_seq #(.WIDTH(W), .STEP(S)) dut (
    .clk    (clk),
    .rst    (rst),
    .mulReq (mul_req),
    .srcA   (src_a),
    .srcB   (src_b),
    .stall  (stall),
    .vld    (vld),
    .result (result),
    .busy   (busy)
  );

  // Clock/reset block
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish, got running expected done");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Idle cycles with mulReq low: nothing active, result held.
  task automatic idle_cycles(input int n);
    mul_req = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check("idle_stall", W'(stall), '0);
      check("idle_vld", W'(vld), '0);
      check("idle_busy", W'(busy), '0);
      check("idle_result_hold", result, last_result);
      @(posedge clk); #1;
    end
  endtask

  // One MUL instruction, called #1 after a posedge. The model: stall in cycles 0..K,
  // vld only in cycle K+1, busy from cycle 1 through K+1, product = a*b mod 2^W.
  task automatic mul_txn(input logic [W-1:0] a, input logic [W-1:0] b,
                         input bit scramble, input bit drop_mid, input bit keep_req);
    logic [W-1:0] exp;
    mul_req = 1'b1;
    src_a   = a;
    src_b   = b;
    exp_q.push_back(a * b);
    for (int c = 0; c <= K + 1; c++) begin
      @(negedge clk);
      check("stall", W'(stall), W'(c <= K));
      check("vld", W'(vld), W'(c == K + 1));
      check("busy", W'(busy), W'(c >= 1));
      if (c == K + 1) begin
        exp = exp_q.pop_front();
        check("result", result, exp);
        last_result = exp;
      end else begin
        check("result_hold", result, last_result);
      end
      @(posedge clk); #1;
      if (scramble && c <= K) begin
        src_a = $urandom;
        src_b = $urandom;
      end
      if (drop_mid && c == 2) mul_req = 1'b0;
      if (c == K) mul_req = 1'b1;
    end
    if (!keep_req) mul_req = 1'b0;
  endtask

  initial begin
    rst         = 1'b1;
    mul_req     = 1'b0;
    src_a       = '0;
    src_b       = '0;
    last_result = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_stall", W'(stall), '0);
    check("reset_vld", W'(vld), '0);
    check("reset_busy", W'(busy), '0);
    check("reset_result", result, '0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    idle_cycles(2);

    // Directed products
    mul_txn(32'd3, 32'd5, 1'b0, 1'b0, 1'b0);
    idle_cycles(1);
    mul_txn(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0);
    mul_txn(32'h0000_FFFF, 32'h0000_FFFF, 1'b0, 1'b0, 1'b0);
    idle_cycles(1);
    mul_txn(32'h0001_0000, 32'h0001_0000, 1'b0, 1'b0, 1'b0);
    mul_txn(32'd0, 32'hDEAD_BEEF, 1'b0, 1'b0, 1'b0);
    idle_cycles(1);

    // Back-to-back with mulReq held through DONE
    mul_txn(32'd7, 32'd6, 1'b0, 1'b0, 1'b1);
    mul_txn(32'd9, 32'd9, 1'b0, 1'b0, 1'b0);
    idle_cycles(2);

    // Operand changes while busy are ignored; mulReq drop mid-sequence tolerated
    mul_txn(32'd12, 32'd12, 1'b1, 1'b0, 1'b0);
    idle_cycles(1);
    mul_txn(32'd1234, 32'd5678, 1'b1, 1'b1, 1'b0);
    idle_cycles(1);

    // Reset at BUSY cycle 4 aborts the operation with no vld pulse
    mul_req = 1'b1;
    src_a   = 32'd5;
    src_b   = 32'd7;
    repeat (4) @(posedge clk);
    @(negedge clk);
    check("abort_busy_before", W'(busy), W'(1));
    rst = 1'b1;
    #1;
    check("abort_stall", W'(stall), '0);
    check("abort_vld", W'(vld), '0);
    check("abort_busy", W'(busy), '0);
    check("abort_result", result, '0);
    last_result = '0;
    mul_req = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    idle_cycles(2);
    mul_txn(32'd2, 32'd2, 1'b0, 1'b0, 1'b0);
    idle_cycles(1);

    // Randomized transactions
    for (int t = 0; t < 30; t++) begin
      logic [W-1:0] a, b;
      a = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : $urandom;
      b = ($urandom_range(0, 3) == 0) ? W'($urandom_range(0, 15)) : $urandom;
      mul_txn(a, b, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              1'($urandom_range(0, 1)));
      if (!mul_req) idle_cycles($urandom_range(0, 2));
    end
    idle_cycles(1);

    check("exp_q_empty", W'(exp_q.size()), '0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
